pio_output_arbiter: RTL

Arbitrates write access to the four 32-bit PIO output banks (hex display 1, hex display 2, red LEDs, green LEDs) between two requesters: requester 0 (host-side PCIe logic) and requester 1 (local board logic, e.g. push-button/switch driven). Requesters are granted round-robin, with at most one write committed per cycle. A per-target hold window stops one requester from overwriting a value the other just wrote, which prevents display flicker. The block sits between the requesters and the PIO export wires of the PCIe core system.

---
 rtl/pio_output_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/pio_output_arbiter.sv
// pio_output_arbiter: round-robin arbiter for two requesters writing four PIO output banks.
// A per-target hold window keeps the non-owner from overwriting a fresh value.
module pio_output_arbiter #(
    parameter int HOLD_CYCLES = 1000,
    parameter int DATA_W      = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              r0_req,
    input  logic [1:0]        r0_sel,
    input  logic [DATA_W-1:0] r0_data,
    output logic              r0_ack,
    input  logic              r1_req,
    input  logic [1:0]        r1_sel,
    input  logic [DATA_W-1:0] r1_data,
    output logic              r1_ack,
    output logic [DATA_W-1:0] hexport_out,
    output logic [DATA_W-1:0] hexport_2_out,
    output logic [DATA_W-1:0] leds_red_out,
    output logic [DATA_W-1:0] leds_green_out,
    output logic [3:0]        owner
);
    localparam int CW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);

    logic [DATA_W-1:0] out_q [4];
    logic [DATA_W-1:0] out_d [4];
    logic [CW-1:0]     hold_q [4];
    logic [CW-1:0]     hold_d [4];
    logic [3:0]        owner_q, owner_d;
    logic              rr_q, rr_d, ack0_q, ack0_d, ack1_q, ack1_d;
    logic              e0, e1, g0, g1, gnt;
    logic [1:0]        gsel;
    logic [DATA_W-1:0] gdata;

    always_comb begin
        e0      = r0_req && !ack0_q && (hold_q[r0_sel] == '0 || !owner_q[r0_sel]);
        e1      = r1_req && !ack1_q && (hold_q[r1_sel] == '0 || owner_q[r1_sel]);
        g0      = e0 && (!e1 || !rr_q);
        g1      = e1 && !g0;
        gnt     = g0 || g1;
        gsel    = g0 ? r0_sel : r1_sel;
        gdata   = g0 ? r0_data : r1_data;
        // pointer moves to whichever requester lost this grant
        rr_d    = gnt ? g0 : rr_q;
        ack0_d  = g0;
        ack1_d  = g1;
        owner_d = owner_q;
        for (int t = 0; t < 4; t++) begin
            hold_d[t] = hold_q[t] != '0 ? hold_q[t] - 1'b1 : '0;
            out_d[t]  = out_q[t];
            if (gnt && gsel == 2'(t)) begin
                hold_d[t]  = HOLD;
                out_d[t]   = gdata;
                owner_d[t] = g1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int t = 0; t < 4; t++) begin
                out_q[t]  <= '0;
                hold_q[t] <= '0;
            end
            owner_q <= '0;
            rr_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            for (int t = 0; t < 4; t++) begin
                out_q[t]  <= out_d[t];
                hold_q[t] <= hold_d[t];
            end
            owner_q <= owner_d;
            rr_q    <= rr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign hexport_out    = out_q[0];
    assign hexport_2_out  = out_q[1];
    assign leds_red_out   = out_q[2];
    assign leds_green_out = out_q[3];
    assign owner          = owner_q;
    assign r0_ack         = ack0_q;
    assign r1_ack         = ack1_q;
endmodule
